keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Scan sequencer for the 4x4 Pmod keypad. Drives one column low at a time and samples the active-low rows after a settle delay. Debounces complete 16-key scans and turns stable changes into press/release events, queued in a small FIFO behind a valid/ready handshake. Sits between the Pmod pins and consumers such as the seven-segment display or a UART.

Parameters:
COL_TICKS, 100000, clk cycles per column slot (1 ms at 100 MHz); must be greater than SETTLE_TICKS.
SETTLE_TICKS, 100, cycles from column drive to row sample (1 us at 100 MHz); must be at least 1.
DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a new key map; must be at least 1.
FIFO_DEPTH, 4, event FIFO entries; must be a power of 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scanning enabled
row  in  4  keypad rows, active low
col  out  4  keypad columns, one low at a time
key_valid  out  1  FIFO head holds an event
key_ready  in  1  consumer accepts head event
key_code  out  4  hex key value of head event
key_pressed  out  1  head event type: 1 = press, 0 = release
key_down  out  1  a debounced key is currently held
overflow  out  1  sticky: an event was dropped
clr_overflow  in  1  clears overflow

Behaviour:
- Reset (async, rst_n=0):
  - col=4'b1111; key_valid=0, key_code=0, key_pressed=0, key_down=0, overflow=0.
  - FIFO empty; FSM in IDLE; all counters and maps cleared.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, EVAL.
  - IDLE -> DRIVE when enable=1, column index c=0, tick counter=0.
  - DRIVE: col = 0111/1011/1101/1110 for c=0..3; go to SETTLE.
  - SETTLE: wait until tick = SETTLE_TICKS; go to SAMPLE.
  - SAMPLE: raw[c*4+r] = ~row[3-r], where r=0 is row pattern 0111. Wait until tick = COL_TICKS-1.
    - If c<3: c++, tick=0, go to DRIVE.
    - If c=3: go to EVAL.
  - EVAL (one cycle): debounce and event generation, then DRIVE with c=0.
  - A full scan is exactly 4*COL_TICKS+1 cycles.
- Key map, indexed by (c, r):
  - c0: 1,4,7,0
  - c1: 2,5,8,F
  - c2: 3,6,9,E
  - c3: A,B,C,D
- Debounce:
  - If raw equals the previous raw, scnt saturating-increments; otherwise scnt=1. Previous raw <= raw.
  - When scnt >= DEBOUNCE_SCANS, stable <= raw.
- Events, evaluated on the updated stable map against the held key:
  - zero bits set and key held -> release(held); key_down=0.
  - exactly one bit set, nothing held -> press(new); key_down=1.
  - exactly one bit set, differs from held -> release(old) then press(new), two pushes on consecutive cycles.
  - two or more bits set -> no event, held state unchanged (ghosting rejected).
- FIFO:
  - Push occurs in EVAL (second push of a pair the following cycle); key_valid rises the cycle after the push.
  - Pop when key_valid && key_ready. key_code/key_pressed are stable while key_valid=1 and not popped.
  - Push when full with no same-cycle pop: event dropped, overflow=1.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - clr_overflow clears overflow; a set in the same cycle wins.
- enable=0 mid-scan: next cycle go to IDLE, col=1111, partial raw discarded, scnt=0.
  - stable map, held key, FIFO contents and overflow are retained; the FIFO remains drainable.
- Tick counter width: clog2(COL_TICKS); it never wraps inside a slot.

Decomposition:
- Package keypad_pkg:
  - column drive patterns COL_PAT[0..3];
  - 16-entry KEY_MAP constant (bit index -> hex code);
  - FSM state encoding;
  - event width constant (5 bits: pressed, code).
- Sub-module keypad_event_fifo: parameterised synchronous FIFO with push/pop, full/empty and drop flag.

Test Plan:
Bench parameters: COL_TICKS=20, SETTLE_TICKS=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4; one scan = 81 cycles.
1. Reset, then enable=1, no keys -> col cycles 1110-safe sequence 0111,1011,1101,1110 every 20 cycles; key_valid stays 0.
2. Hold key 5 (row=1011 while col=1011) for 3 scans, key_ready=1 -> exactly one event, code=5, pressed=1, after the 2nd scan's EVAL; key_down=1. Release it -> code=5, pressed=0.
3. Key 7 held, then key 9 held alone -> release(7) and press(9) on consecutive FIFO entries, in that order.
4. Keys 1 and 2 held together -> no events; key_down unchanged.
5. key_ready=0, generate 5 events -> the 4 oldest are retained, overflow=1. Assert clr_overflow -> overflow=0. Drain -> codes come out in order.
6. enable=0 while col=1101, then rst_n pulsed low mid-scan -> col=1111 immediately; all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the 4x4 keypad scanner
// Contents: FSM state encoding, column drive patterns, bit-index to hex-code
// map, and the packed event format {pressed, code}.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL
  } state_e;

  localparam int EVT_W = 5;

  // Column c is driven low by clearing col[3-c].
  localparam logic [3:0] COL_PAT [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Raw map bit index is c*4+r; this gives the hex legend printed on the key.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  function automatic logic [EVT_W-1:0] mk_evt(input logic pressed, input logic [3:0] code);
    return {pressed, code};
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// rtl/keypad_scan_ctrl_if.sv - key event valid/ready handshake
// Signals: key_valid (head holds an event), key_ready (consumer accepts),
// key_code (hex value), key_pressed (1 = press, 0 = release).
// master = event producer (scanner), slave = consumer.
interface keypad_scan_ctrl_if;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic       key_pressed;

  modport master (output key_valid, output key_code, output key_pressed, input key_ready);
  modport slave  (input key_valid, input key_code, input key_pressed, output key_ready);
endinterface

// File: rtl/keypad_event_fifo.sv
// rtl/keypad_event_fifo.sv - small synchronous FIFO for key events
// Ports: clk, rst_n (async active-low), push/push_data, pop/pop_data (head,
// combinational from storage), full, empty, drop (push refused this cycle).
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module keypad_event_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && !do_push;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad scan, debounce and event queue
// Ports: clk, rst_n (async active-low), enable, row[3:0] (active low),
// col[3:0] (one low at a time), key_if (master: key_valid/key_ready/
// key_code/key_pressed), key_down (debounced key held), overflow (sticky
// drop flag), clr_overflow.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int COL_TICKS      = 100000,
  parameter int SETTLE_TICKS   = 100,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [3:0]                 row,
  output logic [3:0]                 col,
  keypad_scan_ctrl_if.master         key_if,
  output logic                       key_down,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int TW = (COL_TICKS > 1) ? $clog2(COL_TICKS) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] SETTLE_T = TW'(SETTLE_TICKS);
  localparam logic [TW-1:0] LAST_T   = TW'(COL_TICKS - 1);
  localparam logic [SW-1:0] DEB_C    = SW'(DEBOUNCE_SCANS);

  state_e           state_q;
  logic [1:0]       c_q;
  logic [TW-1:0]    tick_q;
  logic [3:0]       col_q;
  logic [15:0]      raw_q, prev_q, stable_q;
  logic [SW-1:0]    scnt_q;
  logic             held_valid_q;
  logic [3:0]       held_code_q;
  logic             pend_q;
  logic [EVT_W-1:0] pend_evt_q;
  logic             overflow_q;

  logic [SW-1:0]    scnt_d;
  logic [15:0]      stable_d;
  logic             held_valid_d;
  logic [3:0]       held_code_d;
  logic             ev_push;
  logic [EVT_W-1:0] ev_data;
  logic             set_pend;
  logic [EVT_W-1:0] pend_evt_d;
  logic [4:0]       nbits;
  logic [3:0]       idx;
  logic [3:0]       new_code;

  logic             eval_go;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [EVT_W-1:0] fifo_wdata, fifo_rdata;

  assign eval_go = (state_q == ST_EVAL) && enable;

  // Debounce and event decision for the scan that just completed.
  always_comb begin
    scnt_d       = (raw_q == prev_q) ? ((scnt_q >= DEB_C) ? scnt_q : scnt_q + 1'b1) : SW'(1);
    stable_d     = (scnt_d >= DEB_C) ? raw_q : stable_q;
    held_valid_d = held_valid_q;
    held_code_d  = held_code_q;
    ev_push      = 1'b0;
    ev_data      = '0;
    set_pend     = 1'b0;
    pend_evt_d   = '0;
    nbits        = '0;
    idx          = '0;
    for (int i = 0; i < 16; i++) begin
      nbits = nbits + 5'(stable_d[i]);
      if (stable_d[i]) idx = 4'(i);
    end
    new_code = KEY_MAP[idx];
    if (nbits == 5'd0) begin
      if (held_valid_q) begin
        ev_push      = 1'b1;
        ev_data      = mk_evt(1'b0, held_code_q);
        held_valid_d = 1'b0;
      end
    end else if (nbits == 5'd1) begin
      if (!held_valid_q) begin
        ev_push      = 1'b1;
        ev_data      = mk_evt(1'b1, new_code);
        held_valid_d = 1'b1;
        held_code_d  = new_code;
      end else if (new_code != held_code_q) begin
        // Release of the old key goes out now, the press follows next cycle.
        ev_push     = 1'b1;
        ev_data     = mk_evt(1'b0, held_code_q);
        set_pend    = 1'b1;
        pend_evt_d  = mk_evt(1'b1, new_code);
        held_code_d = new_code;
      end
    end
    // Two or more keys: ambiguous matrix reading, hold state as is.
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      c_q          <= '0;
      tick_q       <= '0;
      col_q        <= 4'b1111;
      raw_q        <= '0;
      prev_q       <= '0;
      stable_q     <= '0;
      scnt_q       <= '0;
      held_valid_q <= 1'b0;
      held_code_q  <= '0;
      pend_q       <= 1'b0;
      pend_evt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pend_q <= 1'b0;
      if (!enable) begin
        // Abandon the scan in progress; debounced state and queue survive.
        state_q <= ST_IDLE;
        col_q   <= 4'b1111;
        c_q     <= '0;
        tick_q  <= '0;
        raw_q   <= '0;
        scnt_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_DRIVE;
            c_q     <= '0;
            tick_q  <= '0;
          end
          ST_DRIVE: begin
            col_q   <= COL_PAT[c_q];
            tick_q  <= tick_q + 1'b1;
            state_q <= ST_SETTLE;
          end
          ST_SETTLE: begin
            tick_q <= tick_q + 1'b1;
            if (tick_q >= SETTLE_T) state_q <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            for (int r = 0; r < 4; r++) raw_q[{c_q, r[1:0]}] <= ~row[3-r];
            if (tick_q >= LAST_T) begin
              tick_q <= '0;
              if (c_q == 2'd3) begin
                state_q <= ST_EVAL;
              end else begin
                c_q     <= c_q + 1'b1;
                state_q <= ST_DRIVE;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          ST_EVAL: begin
            prev_q       <= raw_q;
            scnt_q       <= scnt_d;
            stable_q     <= stable_d;
            held_valid_q <= held_valid_d;
            held_code_q  <= held_code_d;
            pend_q       <= set_pend;
            pend_evt_q   <= pend_evt_d;
            state_q      <= ST_DRIVE;
            c_q          <= '0;
            tick_q       <= '0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (fifo_drop)         overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  assign fifo_push  = (eval_go && ev_push) || pend_q;
  assign fifo_wdata = pend_q ? pend_evt_q : ev_data;
  assign fifo_pop   = !fifo_empty && key_if.key_ready;

  keypad_event_fifo #(
    .W     (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign col                = col_q;
  assign key_down           = held_valid_q;
  assign overflow           = overflow_q;
  assign key_if.key_valid   = !fifo_empty;
  assign key_if.key_code    = fifo_rdata[3:0];
  assign key_if.key_pressed = fifo_rdata[4];

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - self-checking bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_down;
  logic       overflow;
  logic       clr_overflow = 1'b0;
  logic [15:0] keys = '0;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  logic [4:0] exp_q [$];

  keypad_scan_ctrl_if kif ();

  keypad_scan_ctrl #(
    .COL_TICKS      (20),
    .SETTLE_TICKS   (4),
    .DEBOUNCE_SCANS (2),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .row          (row),
    .col          (col),
    .key_if       (kif),
    .key_down     (key_down),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key at (c, r) pulls row[3-r] low while col[3-c] is low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[3-c] && keys[c*4+r]) row[3-r] = 1'b0;
  end

  function automatic logic [15:0] km(input logic [3:0] code);
    int p;
    case (code)
      4'h1: p = 0;  4'h4: p = 1;  4'h7: p = 2;  4'h0: p = 3;
      4'h2: p = 4;  4'h5: p = 5;  4'h8: p = 6;  4'hF: p = 7;
      4'h3: p = 8;  4'h6: p = 9;  4'h9: p = 10; 4'hE: p = 11;
      4'hA: p = 12; 4'hB: p = 13; 4'hC: p = 14; default: p = 15;
    endcase
    return 16'(1) << p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted event is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && kif.key_valid && kif.key_ready) begin
      n_pop++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_event observed=%0h expected=none", {kif.key_pressed, kif.key_code});
      end
      if (exp_q.size() != 0) begin
        logic [4:0] e;
        e = exp_q.pop_front();
        total++;
        assert ({kif.key_pressed, kif.key_code} === e) else begin
          bad++;
          $error("FAIL event observed=%0h expected=%0h", {kif.key_pressed, kif.key_code}, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] p, output int cyc);
    cyc = 0;
    while (col !== p && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 1000) chk("wait_col_timeout", 32'(col), 32'(p));
  endtask

  task automatic next_scan();
    int cyc;
    cyc = 0;
    while (col === 4'b0111 && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    wait_col(4'b0111, cyc);
  endtask

  task automatic hold(input logic [15:0] k, input int scans);
    keys = k;
    repeat (scans) next_scan();
  endtask

  initial begin
    int cyc;
    int base;
    kif.key_ready = 1'b1;

    // Reset state
    tick(3);
    chk("rst_col", 32'(col), 32'hF);
    chk("rst_valid", 32'(kif.key_valid), 0);
    chk("rst_code", 32'(kif.key_code), 0);
    chk("rst_pressed", 32'(kif.key_pressed), 0);
    chk("rst_down", 32'(key_down), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_col", 32'(col), 32'hF);

    // 1. Column timing with no keys
    enable = 1'b1;
    wait_col(4'b0111, cyc);
    wait_col(4'b1011, cyc); chk("slot0_len", 32'(cyc), 20);
    wait_col(4'b1101, cyc); chk("slot1_len", 32'(cyc), 20);
    wait_col(4'b1110, cyc); chk("slot2_len", 32'(cyc), 20);
    wait_col(4'b0111, cyc); chk("slot3_eval_len", 32'(cyc), 21);
    chk("idle_no_events", 32'(n_pop), 0);

    // 2. Key 5 press latency, then release
    exp_q.push_back({1'b1, 4'h5});
    keys = km(4'h5);
    next_scan();
    chk("press5_not_early", 32'(n_pop), 0);
    next_scan();
    chk("press5_after_scan2", 32'(n_pop), 1);
    next_scan();
    chk("press5_single", 32'(n_pop), 1);
    chk("press5_down", 32'(key_down), 1);
    exp_q.push_back({1'b0, 4'h5});
    hold('0, 3);
    chk("rel5_down", 32'(key_down), 0);

    // 3. Key 7 then key 9 alone: release 7 precedes press 9
    exp_q.push_back({1'b1, 4'h7});
    hold(km(4'h7), 3);
    exp_q.push_back({1'b0, 4'h7});
    exp_q.push_back({1'b1, 4'h9});
    hold(km(4'h9), 3);
    chk("swap_down", 32'(key_down), 1);
    exp_q.push_back({1'b0, 4'h9});
    hold('0, 3);

    // 4. Two keys together are ignored
    base = n_pop;
    hold(km(4'h1) | km(4'h2), 3);
    chk("ghost_no_event", 32'(n_pop - base), 0);
    chk("ghost_down", 32'(key_down), 0);
    hold('0, 3);
    chk("ghost_release_no_event", 32'(n_pop - base), 0);

    // 5. Overflow with consumer stalled
    kif.key_ready = 1'b0;
    base = n_pop;
    exp_q.push_back({1'b1, 4'hA});
    hold(km(4'hA), 3);
    exp_q.push_back({1'b0, 4'hA});
    hold('0, 3);
    exp_q.push_back({1'b1, 4'hB});
    hold(km(4'hB), 3);
    exp_q.push_back({1'b0, 4'hB});
    chk("ovf_clear_before", 32'(overflow), 0);
    hold('0, 3);
    hold(km(4'hC), 3);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_head_valid", 32'(kif.key_valid), 1);
    chk("ovf_head_code", 32'(kif.key_code), 32'hA);
    chk("ovf_head_pressed", 32'(kif.key_pressed), 1);
    chk("ovf_no_pop", 32'(n_pop - base), 0);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    kif.key_ready = 1'b1;
    tick(10);
    chk("drain_count", 32'(n_pop - base), 4);
    chk("drain_empty", 32'(exp_q.size()), 0);
    chk("c_held", 32'(key_down), 1);
    exp_q.push_back({1'b0, 4'hC});
    hold('0, 3);

    // 6. Disable mid-scan, then asynchronous reset mid-scan
    wait_col(4'b1101, cyc);
    enable = 1'b0;
    tick(1);
    chk("dis_col", 32'(col), 32'hF);
    tick(5);
    chk("dis_col_held", 32'(col), 32'hF);
    enable = 1'b1;
    kif.key_ready = 1'b0;
    hold(km(4'hD), 3);
    chk("pre_rst_valid", 32'(kif.key_valid), 1);
    chk("pre_rst_code", 32'(kif.key_code), 32'hD);
    chk("pre_rst_down", 32'(key_down), 1);
    wait_col(4'b1011, cyc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_col", 32'(col), 32'hF);
    chk("arst_valid", 32'(kif.key_valid), 0);
    chk("arst_code", 32'(kif.key_code), 0);
    chk("arst_pressed", 32'(kif.key_pressed), 0);
    chk("arst_down", 32'(key_down), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    keys = '0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
